// File: rtl/cla_multibyte_sequencer.sv
// cla_multibyte_sequencer: byte-serial wide add/sub through one shared
// external 8-bit carry-lookahead adder, least-significant byte first.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start, sub     request (sampled in IDLE) and op select (0 add, 1 sub)
//   a, b           operands, latched on accepted start
//   busy, done     busy in RUN/DONE, done is a one-cycle pulse
//   sum, cout, ovf result, carry-out (sub: 1 = no borrow), signed overflow
//   add_a, add_b   operand bytes to the external adder
//   add_cin        carry into the external adder
//   add_s          adder sum byte (combinational)
//   add_c7, add_c6 adder carries out of bit 7 and bit 6
module cla_multibyte_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_c7,
  input  logic                  add_c6
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic            last_byte;

  assign last_byte = (idx_q == LAST);

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte select of the latched operands for the current pass
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          // B is stored pre-inverted for subtract; the +1 of
          // two's complement enters as the first carry-in.
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[i*8 +: 8] = add_s;
        end
        carry_d = add_c7;
        if (last_byte) begin
          cout_d = add_c7;
          ovf_d  = add_c7 ^ add_c6;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      RUN: begin
        busy    = 1'b1;
        add_a   = a_byte;
        add_b   = b_byte;
        add_cin = carry_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_multibyte_sequencer.sv
// tb_cla_multibyte_sequencer: directed stimulus with a scoreboard queue;
// a monitor pops expected results whenever done is seen.
module tb_cla_multibyte_sequencer;

  localparam int NB = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [31:0] scyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_c7;
  logic        add_c6;

  logic [8:0]  s9;
  logic [7:0]  s7;

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          done_cnt;
  exp_t        sb[$];

  cla_multibyte_sequencer #(.NBYTES(NB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_s   (add_s),
    .add_c7  (add_c7),
    .add_c6  (add_c6)
  );

  // External 8-bit adder
  always_comb begin
    s9     = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
    s7     = {1'b0, add_a[6:0]} + {1'b0, add_b[6:0]} + {7'b0, add_cin};
    add_s  = s9[7:0];
    add_c7 = s9[8];
    add_c6 = s7[7];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop on done, check result, latency, pulse width, hold
  initial begin
    exp_t e;
    logic pend;
    logic [31:0] held;
    pend = 1'b0;
    held = '0;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("sum_held", {32'b0, sum}, {32'b0, held});
        pend = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 required none at cyc %0d",
                   cyc);
        end else begin
          e = sb.pop_front();
          check("sum", {32'b0, sum}, {32'b0, e.s});
          check("cout", {63'b0, cout}, {63'b0, e.c});
          check("ovf", {63'b0, ovf}, {63'b0, e.o});
          check("latency", 64'(cyc - int'(e.scyc)), 64'd5);
          held = e.s;
          pend = 1'b1;
        end
      end
    end
  end

  // Returns at a negedge with busy low, or flags a timeout
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic is, input logic [31:0] es,
                       input logic ec, input logic eo,
                       input bit exp_it, input bit hold,
                       output int scyc);
    exp_t e;
    wait_idle();
    a     = ia;
    b     = ib;
    sub   = is;
    start = 1'b1;
    scyc  = cyc;
    if (exp_it) begin
      e.s    = es;
      e.c    = ec;
      e.o    = eo;
      e.scyc = 32'(cyc);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int sc;
    int prev;
    int d0;
    int n;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_sum", {32'b0, sum}, 64'd0);
    check("rst_cout_ovf", {62'b0, cout, ovf}, 64'd0);
    check("rst_adder_in", {47'b0, add_a, add_b, add_cin}, 64'd0);
    rst = 1'b0;

    // 1 / 2: addition
    issue(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0,
          1'b1, 1'b0, sc);
    check("busy_in_run", {63'b0, busy}, 64'd1);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0,
          1'b1, 1'b0, sc);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1,
          1'b1, 1'b0, sc);

    // 3: subtraction
    issue(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0,
          1'b1, 1'b0, sc);
    issue(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1,
          1'b1, 1'b0, sc);

    // 4: start and operand changes during RUN are ignored
    wait_idle();
    d0 = done_cnt;
    issue(32'h55555555, 32'hAAAAAAAA, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0,
          1'b1, 1'b0, sc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1;
      a     = 32'h12345678;
      b     = 32'h12345678;
      sub   = 1'b1;
      check("busy_hold", {63'b0, busy}, 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("single_done", 64'(done_cnt - d0), 64'd1);

    // 5: reset aborts at idx=2
    issue(32'h11111111, 32'h22222222, 1'b0, 32'h0, 1'b0, 1'b0,
          1'b0, 1'b0, sc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_sum", {32'b0, sum}, 64'd0);
    check("abort_cout_ovf", {62'b0, cout, ovf}, 64'd0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    issue(32'h6C6C6C6C, 32'hCACACACA, 1'b0, 32'h37373736, 1'b1, 1'b0,
          1'b1, 1'b0, sc);

    // 6: back-to-back with start held high
    issue(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0,
          1'b1, 1'b1, sc);
    prev = sc;
    issue(32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0,
          1'b1, 1'b1, sc);
    check("issue_interval_1", 64'(sc - prev), 64'd6);
    prev = sc;
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1,
          1'b1, 1'b0, sc);
    check("issue_interval_2", 64'(sc - prev), 64'd6);

    // rst with start: stays idle
    wait_idle();
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_busy0", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_start_busy1", {63'b0, busy}, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_start_after", {63'b0, busy}, 64'd0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_multibyte_sequencer.md
# cla_multibyte_sequencer

Sequencing controller that performs NBYTES×8-bit add/subtract operations by reusing one external 8-bit carry-lookahead adder (cla8bitAdder) byte-serially, least-significant byte first. It chains the carry between passes and reports the final carry-out and signed overflow. It sits between a start/done command interface and the shared adder datapath, so the design can do wide arithmetic without instantiating a wide adder.

## Interface
Parameters:
- NBYTES, default 4: operand width in bytes (≥2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  operation select, latched with start: 0 = A+B, 1 = A−B.
- a  input  8*NBYTES  operand A; latched on accepted start.
- b  input  8*NBYTES  operand B; latched on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse in DONE.
- sum  output  8*NBYTES  result; valid from done, held until the next accepted start.
- cout  output  1  final carry-out of MSB byte (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = adder c[7] XOR adder c[6] on MSB pass.
- add_a  output  8  adder operand byte.
- add_b  output  8  adder operand byte (B byte, inverted when sub).
- add_cin  output  1  adder carry-in.
- add_s  input  8  adder sum, combinational from add_a/add_b/add_cin.
- add_c7  input  1  adder carry out of bit 7.
- add_c6  input  1  adder carry out of bit 6 (carry into bit 7).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: add_a, add_b and add_cin are driven 0, and the adder inputs are ignored.
  - start=1 latches a, the effective B (b or ~b, per sub), and sub.
  - It clears byte index idx to 0, sets carry register = sub, clears sum, cout and ovf to 0, and goes to RUN.
- RUN:
  - Drive add_a = A[idx], add_b = Beff[idx], add_cin = carry.
  - At each edge, write add_s into sum byte idx and set carry <= add_c7.
  - If idx ≠ NBYTES−1: idx <= idx+1 and stay in RUN.
  - If idx = NBYTES−1: cout <= add_c7, ovf <= add_c7 ^ add_c6, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored in RUN and DONE; there is no queueing.
- Changes on a, b and sub while busy have no effect, because the operands are latched.
- Subtraction is two's complement: A + ~B + 1, with the +1 supplied as the initial carry. All arithmetic is modulo 2^(8*NBYTES).
- idx width is clog2(NBYTES). idx never wraps, because the transition is decided at NBYTES−1.
- Reset in any state applies the reset values on the next edge and aborts any operation in flight. No done pulse follows an abort.
- Reset values: state = IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, idx 0, carry 0, add_a/add_b/add_cin 0.
- rst and start asserted together: rst wins.

## Timing
- The adder is combinational. Each byte pass completes in one clock, with add_s sampled on the same edge that advances idx.
- If start is accepted at edge k:
  - RUN occupies cycles k+1 … k+NBYTES.
  - done is high in cycle k+NBYTES+1, with sum, cout and ovf already valid.
  - Latency is NBYTES+1 cycles, start edge to done cycle.
- busy rises the cycle after the accepted start and falls the cycle after done.
- The next start is accepted in the first IDLE cycle. The minimum issue interval is NBYTES+2 cycles.
- sum is updated byte-by-byte during RUN. Consumers must read only on done or later.

## Test plan
All scenarios use NBYTES=4.
1. a=0x000000FF, b=0x00000001, sub=0 → sum=0x00000100, cout=0, ovf=0; done exactly 5 cycles after the start edge; done high for one cycle.
2. a=0xFFFFFFFF, b=0x00000001, sub=0 → sum=0x00000000, cout=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1.
3. Subtract with sub=1:
   - a=0x00000005, b=0x00000007 → sum=0xFFFFFFFE, cout=0, ovf=0.
   - a=0x80000000, b=0x00000001 → sum=0x7FFFFFFF, cout=1, ovf=1.
4. Start a=0x55555555 + b=0xAAAAAAAA. During RUN, pulse start and change a/b to 0x12345678.
   - Required: a single done.
   - Result sum=0xFFFFFFFF, cout=0, ovf=0.
   - busy stays high with no extra operation.
5. Assert rst during RUN at idx=2 → next cycle: busy=0, sum=0, cout=0, ovf=0, no done. A following start with a=0x6C6C6C6C, b=0xCACACACA, sub=0 → sum=0x37373736, cout=1, ovf=0.
6. Back-to-back: assert start continuously → operations accepted every 6 cycles. sum stays stable from each done until the next accepted start. rst=1 with start=1 → stays in IDLE.
